// File: rtl/rx_d2c_point_test_responder.sv
// rx_d2c_point_test_responder: partner-side sideband responder for the RX data-to-clock point test
module rx_d2c_point_test_responder #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int NUM_LANES    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rx_d2c_pt_en,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_sb_burst_count,
  input  logic                    i_sb_comparison_mode,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  input  logic [NUM_LANES-1:0]    i_lane_errors,
  input  logic                    i_aggregate_error,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic                    o_valid_tx,
  output logic                    o_comparator_clear,
  output logic                    o_comparator_en,
  output logic                    o_burst_count,
  output logic                    o_comparison_mode,
  output logic [NUM_LANES-1:0]    o_lane_result,
  output logic                    o_result_valid,
  output logic                    o_rx_d2c_pt_done_rx
);
  localparam logic [SB_MSG_WIDTH-1:0] START_REQ       = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] START_RESP      = SB_MSG_WIDTH'(2);
  localparam logic [SB_MSG_WIDTH-1:0] LFSR_CLR_REQ    = SB_MSG_WIDTH'(3);
  localparam logic [SB_MSG_WIDTH-1:0] LFSR_CLR_RESP   = SB_MSG_WIDTH'(4);
  localparam logic [SB_MSG_WIDTH-1:0] COUNT_DONE_REQ  = SB_MSG_WIDTH'(5);
  localparam logic [SB_MSG_WIDTH-1:0] COUNT_DONE_RESP = SB_MSG_WIDTH'(6);
  localparam logic [SB_MSG_WIDTH-1:0] END_REQ         = SB_MSG_WIDTH'(7);
  localparam logic [SB_MSG_WIDTH-1:0] END_RESP        = SB_MSG_WIDTH'(8);

  typedef enum logic [2:0] {IDLE, WAIT_START, WAIT_CLR, COMPARE, WAIT_END, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic                    valid_q, valid_d;
  logic                    clr_q, clr_d;
  logic                    cmp_en_q, cmp_en_d;
  logic                    burst_q, burst_d;
  logic                    mode_q, mode_d;
  logic [NUM_LANES-1:0]    result_q, result_d;
  logic                    rvalid_q, rvalid_d;
  logic                    done_q, done_d;
  logic [SB_MSG_WIDTH-1:0] req;

  // Unqualified codes collapse to 0, which matches no request
  assign req = i_rx_msg_valid ? i_decoded_SB_msg : '0;

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    valid_d  = (i_falling_edge_busy && !i_rx_valid) ? 1'b0 : valid_q;
    clr_d    = 1'b0;
    cmp_en_d = cmp_en_q;
    burst_d  = burst_q;
    mode_d   = mode_q;
    result_d = result_q;
    rvalid_d = rvalid_q;
    done_d   = done_q;
    case (state_q)
      IDLE: state_d = i_rx_d2c_pt_en ? WAIT_START : IDLE;
      WAIT_START: if (req == START_REQ) begin
        state_d = WAIT_CLR;
        burst_d = i_sb_burst_count;
        mode_d  = i_sb_comparison_mode;
        msg_d   = START_RESP;
        valid_d = 1'b1;
      end
      WAIT_CLR: if (req == LFSR_CLR_REQ) begin
        state_d  = COMPARE;
        clr_d    = 1'b1;
        cmp_en_d = 1'b1;
        msg_d    = LFSR_CLR_RESP;
        valid_d  = 1'b1;
      end
      COMPARE: if (req == COUNT_DONE_REQ) begin
        state_d  = WAIT_END;
        cmp_en_d = 1'b0;
        result_d = mode_q ? {NUM_LANES{~i_aggregate_error}} : ~i_lane_errors;
        rvalid_d = 1'b1;
        msg_d    = COUNT_DONE_RESP;
        valid_d  = 1'b1;
      end
      WAIT_END: if (req == END_REQ) begin
        state_d = DONE;
        done_d  = 1'b1;
        msg_d   = END_RESP;
        valid_d = 1'b1;
      end
      default: ;
    endcase
    // Dropping enable aborts from any state and wipes every output
    if (!i_rx_d2c_pt_en) begin
      state_d  = IDLE;
      msg_d    = '0;
      valid_d  = 1'b0;
      clr_d    = 1'b0;
      cmp_en_d = 1'b0;
      burst_d  = 1'b0;
      mode_d   = 1'b0;
      result_d = '0;
      rvalid_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      msg_q    <= '0;
      valid_q  <= 1'b0;
      clr_q    <= 1'b0;
      cmp_en_q <= 1'b0;
      burst_q  <= 1'b0;
      mode_q   <= 1'b0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      valid_q  <= valid_d;
      clr_q    <= clr_d;
      cmp_en_q <= cmp_en_d;
      burst_q  <= burst_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  assign o_encoded_SB_msg_tx = msg_q;
  assign o_valid_tx          = valid_q;
  assign o_comparator_clear  = clr_q;
  assign o_comparator_en     = cmp_en_q;
  assign o_burst_count       = burst_q;
  assign o_comparison_mode   = mode_q;
  assign o_lane_result       = result_q;
  assign o_result_valid      = rvalid_q;
  assign o_rx_d2c_pt_done_rx = done_q;
endmodule

// File: tb/tb_rx_d2c_point_test_responder.sv
// tb_rx_d2c_point_test_responder: directed handshake vectors with hand-computed expectations
module tb_rx_d2c_point_test_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        msg_valid = 1'b0;
  logic [3:0]  msg = '0;
  logic        sb_burst = 1'b0;
  logic        sb_mode = 1'b0;
  logic        feb = 1'b0;
  logic        rx_valid = 1'b0;
  logic [15:0] lane_err = '0;
  logic        agg_err = 1'b0;
  logic [3:0]  tx_msg;
  logic        valid_tx, cmp_clr, cmp_en, burst, mode, res_valid, done;
  logic [15:0] lane_res;
  logic [26:0] all_out;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  rx_d2c_point_test_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_d2c_pt_en(en),
    .i_rx_msg_valid(msg_valid), .i_decoded_SB_msg(msg),
    .i_sb_burst_count(sb_burst), .i_sb_comparison_mode(sb_mode),
    .i_falling_edge_busy(feb), .i_rx_valid(rx_valid),
    .i_lane_errors(lane_err), .i_aggregate_error(agg_err),
    .o_encoded_SB_msg_tx(tx_msg), .o_valid_tx(valid_tx),
    .o_comparator_clear(cmp_clr), .o_comparator_en(cmp_en),
    .o_burst_count(burst), .o_comparison_mode(mode),
    .o_lane_result(lane_res), .o_result_valid(res_valid),
    .o_rx_d2c_pt_done_rx(done)
  );

  assign all_out = {tx_msg, valid_tx, cmp_clr, cmp_en, burst, mode, lane_res, res_valid, done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] code);
    msg_valid = 1'b1;
    msg = code;
    step();
    msg_valid = 1'b0;
    msg = '0;
  endtask

  initial begin
    #12;
    chk("reset_outputs", 32'(all_out), 0);
    rst_n = 1'b1;
    step();
    chk("idle_outputs", 32'(all_out), 0);
    // enable rises together with a START_REQ: request must not be taken yet
    en = 1'b1;
    msg_valid = 1'b1;
    msg = 4'd1;
    sb_burst = 1'b1;
    sb_mode = 1'b0;
    step();
    chk("start_on_en_edge_ignored", 32'(valid_tx), 0);
    step();
    msg_valid = 1'b0;
    msg = '0;
    chk("start_resp_code", 32'(tx_msg), 2);
    chk("start_resp_valid", 32'(valid_tx), 1);
    chk("burst_latched", 32'(burst), 1);
    chk("mode_latched", 32'(mode), 0);
    feb = 1'b1;
    rx_valid = 1'b1;
    step();
    chk("valid_held_rx_busy", 32'(valid_tx), 1);
    rx_valid = 1'b0;
    step();
    feb = 1'b0;
    chk("valid_cleared", 32'(valid_tx), 0);
    chk("msg_held_after_clear", 32'(tx_msg), 2);
    req(4'd5);
    chk("ooo_count_done_msg", 32'(tx_msg), 2);
    chk("ooo_count_done_valid", 32'(valid_tx), 0);
    msg = 4'd3;
    step();
    msg = '0;
    chk("unqualified_clr_en", 32'(cmp_en), 0);
    chk("unqualified_clr_valid", 32'(valid_tx), 0);
    // clear request coincident with a valid-clear pulse: send wins
    feb = 1'b1;
    req(4'd3);
    feb = 1'b0;
    chk("clr_resp_code", 32'(tx_msg), 4);
    chk("clr_send_wins", 32'(valid_tx), 1);
    chk("clr_pulse_high", 32'(cmp_clr), 1);
    chk("cmp_en_rise", 32'(cmp_en), 1);
    lane_err = 16'h0005;
    step();
    chk("clr_pulse_low", 32'(cmp_clr), 0);
    chk("cmp_en_held", 32'(cmp_en), 1);
    req(4'd5);
    chk("cd_resp_code", 32'(tx_msg), 6);
    chk("lane_result_perlane", 32'(lane_res), 32'hFFFA);
    chk("result_valid", 32'(res_valid), 1);
    chk("cmp_en_fall", 32'(cmp_en), 0);
    req(4'd1);
    chk("repeat_start_ignored", 32'(tx_msg), 6);
    req(4'd7);
    chk("end_resp_code", 32'(tx_msg), 8);
    chk("done_set", 32'(done), 1);
    step();
    chk("done_held", 32'(done), 1);
    en = 1'b0;
    step();
    chk("disable_clears_all", 32'(all_out), 0);
    // aggregate mode, failing then passing
    for (int k = 0; k < 2; k++) begin
      en = 1'b1;
      step();
      sb_burst = 1'b0;
      sb_mode = 1'b1;
      req(4'd1);
      chk("agg_mode_latched", 32'(mode), 1);
      req(4'd3);
      agg_err = (k == 0);
      lane_err = 16'h0000;
      req(4'd5);
      chk("agg_lane_result", 32'(lane_res), (k == 0) ? 32'h0000 : 32'hFFFF);
      chk("agg_result_valid", 32'(res_valid), 1);
      req(4'd7);
      chk("agg_done", 32'(done), 1);
      en = 1'b0;
      step();
    end
    agg_err = 1'b0;
    // abort in COMPARE and restart
    en = 1'b1;
    step();
    sb_mode = 1'b0;
    req(4'd1);
    req(4'd3);
    chk("abort_pre_cmp_en", 32'(cmp_en), 1);
    en = 1'b0;
    msg_valid = 1'b1;
    msg = 4'd5;
    step();
    msg_valid = 1'b0;
    msg = '0;
    chk("abort_all_zero", 32'(all_out), 0);
    en = 1'b1;
    step();
    req(4'd3);
    chk("restart_clr_ignored", 32'(valid_tx), 0);
    req(4'd1);
    chk("restart_start_resp", 32'(tx_msg), 2);
    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_zero", 32'(all_out), 0);
    #1;
    rst_n = 1'b1;
    en = 1'b0;
    step();
    chk("post_reset_idle", 32'(all_out), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
